i2c_byte_master: RTL and testbench
==================================

I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 SHALL have parameter QUARTER_DIV, default 68, meaning clk_i cycles per quarter SCL bit period (about 99 kHz at 27 MHz).
REQ-002 SHALL have port clk_i  input  1  system clock; the block has one clock and all logic is on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port enable_i  input  1  command request, held high by the controller until complete_o is seen.
REQ-005 SHALL have port instruction_i  input  2  command code: 0 START, 1 STOP, 2 READ_BYTE, 3 WRITE_BYTE.
REQ-006 SHALL have port byte_to_send_i  input  8  WRITE_BYTE payload.
REQ-007 SHALL have port byte_received_o  output  8  last READ_BYTE result.
REQ-008 SHALL have port complete_o  output  1  high when the command is finished.
REQ-009 SHALL have port ack_error_o  output  1  high when the slave NACKed the last WRITE_BYTE.
REQ-010 SHALL have port busy_o  output  1  high while a command is executing.
REQ-011 SHALL have port scl_o  output  1  SCL level (single master, push-pull).
REQ-012 SHALL have port sda_oe_o  output  1  SDA open-drain control; 1 pulls SDA low, 0 releases it.
REQ-013 SHALL have port sda_i  input  1  sampled SDA line.

Function
REQ-014 SHALL implement the states IDLE, START, STOP, WRITE, READ and DONE.
REQ-015 In IDLE with enable_i=1, SHALL capture instruction_i and byte_to_send_i, set busy_o=1, enter the state for the command and clear the divider, phase and bit counters; that cycle is "accept".
REQ-016 SHALL divide each bit into phases q0..q3, each QUARTER_DIV cycles; SCL is low in q0-q1 and high in q2-q3; SDA changes only at q0 entry; SDA is sampled at q3 entry.
REQ-017 START SHALL be one bit: q0 releases SDA and sets SCL low only if SCL is already low; q1 raises SCL; q2 pulls SDA low with SCL high; q3 drives SCL low. This supports repeated START.
REQ-018 STOP SHALL be one bit: q0 sets SCL low and SDA low; q1 raises SCL; q2 releases SDA with SCL high; q3 holds.
REQ-019 WRITE SHALL send 9 bits: payload bits 7 down to 0, then an ACK bit with SDA released; sda_i sampled in the ACK bit is latched into ack_error_o (1 means NACK).
REQ-020 READ SHALL send 9 bits with SDA released for bits 0-7 and shift sda_i MSB-first; byte_received_o updates at the end of bit 7; bit 8 drives ACK or NACK per REQ-021.
REQ-021 A READ_BYTE that directly follows another READ_BYTE (no intervening command) SHALL NACK (SDA released); any other READ_BYTE SHALL ACK (SDA low); START resets this tracking.
REQ-022 After the last phase of a command, SHALL enter DONE one cycle later with complete_o=1 and busy_o=0. complete_o rises 4*QUARTER_DIV*N+1 cycles after accept, where N=1 for START/STOP and N=9 for READ/WRITE.
REQ-023 In DONE, complete_o SHALL stay high while enable_i=1; when enable_i=0 it SHALL clear complete_o and return to IDLE; no new command is accepted until then.
REQ-024 If enable_i drops mid-command, the command SHALL still finish; it then goes directly to IDLE without asserting complete_o.
REQ-025 complete_o SHALL be 0 in IDLE and during execution, so the controller always sees low then high.
REQ-026 Between commands, SCL SHALL hold its last level and SDA SHALL hold its last drive (SCL low after START/READ/WRITE, SDA released after STOP).
REQ-027 ack_error_o SHALL change only at WRITE ACK sampling; byte_received_o SHALL change only at READ bit-7 completion.

Reset
REQ-028 When rst_ni=0 at a clock edge, SHALL enter IDLE and set scl_o=1, sda_oe_o=0, complete_o=0, busy_o=0, ack_error_o=0, byte_received_o=0x00, and clear all counters and read-tracking, including during a command; the aborted command never completes.

Verification (QUARTER_DIV=2)
REQ-029 START from reset -> SDA falls while scl_o=1, scl_o then falls, and complete_o rises at cycle 9 after accept.
REQ-030 WRITE 0x90 with slave ACK -> SDA bits 1,0,0,1,0,0,0,0 are stable at each SCL high, ack_error_o=0, and complete_o rises at cycle 73; repeating with a NACK gives ack_error_o=1.
REQ-031 START, WRITE 0x91, then READ with slave sending 0x12, then READ with slave sending 0x34, then STOP -> byte_received_o=0x12 with ACK driven, then 0x34 with SDA released (NACK); STOP leaves SCL high and SDA released.
REQ-032 enable_i held high for 20 cycles after complete_o -> no new command and busy_o=0; enable_i low -> complete_o=0 next cycle.
REQ-033 rst_ni pulsed low during WRITE bit 4 -> next cycle scl_o=1, sda_oe_o=0, busy_o=0, complete_o stays 0; a fresh START then runs normally.

Source files
------------

// File: rtl/i2c_byte_master_if.sv
// rtl/i2c_byte_master_if.sv - command handshake and I2C pin bundle for i2c_byte_master
// master modport: the command controller (drives requests, sees results).
// slave modport:  the byte engine (sees requests, drives results and bus pins).
interface i2c_byte_master_if;
    logic       enable;
    logic [1:0] instruction;
    logic [7:0] byte_to_send;
    logic [7:0] byte_received;
    logic       complete;
    logic       ack_error;
    logic       busy;
    logic       scl;
    logic       sda_oe;
    logic       sda;

    modport master (
        output enable, instruction, byte_to_send,
        input  byte_received, complete, ack_error, busy
    );

    modport slave (
        input  enable, instruction, byte_to_send, sda,
        output byte_received, complete, ack_error, busy, scl, sda_oe
    );
endinterface

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - single-master I2C byte engine (START/STOP/READ_BYTE/WRITE_BYTE)
// Ports: clk_i, rst_ni (sync, active-low); enable_i/instruction_i/byte_to_send_i command
// request; byte_received_o, complete_o, ack_error_o, busy_o status; scl_o push-pull
// clock; sda_oe_o open-drain pull-down; sda_i sampled line.
module i2c_byte_master #(
    parameter int QUARTER_DIV = 68
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [1:0] instruction_i,
    input  logic [7:0] byte_to_send_i,
    output logic [7:0] byte_received_o,
    output logic       complete_o,
    output logic       ack_error_o,
    output logic       busy_o,
    output logic       scl_o,
    output logic       sda_oe_o,
    input  logic       sda_i
);
    localparam int DW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(QUARTER_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_WRITE, S_READ, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    phase_q, phase_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_q, rx_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          complete_q, complete_d;
    logic          ack_err_q, ack_err_d;
    logic          nack_q, nack_d;
    logic          last_read_q, last_read_d;

    // Phase-entry bookkeeping: which phase of which bit is being entered this edge.
    logic          enter;
    state_t        ent_state;
    logic [1:0]    ent_phase;
    logic [3:0]    ent_bit;
    logic [7:0]    ent_tx;
    logic [3:0]    last_bit;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        scl_d       = scl_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        complete_d  = complete_q;
        ack_err_d   = ack_err_q;
        nack_d      = nack_q;
        last_read_d = last_read_q;
        enter       = 1'b0;
        ent_state   = state_q;
        ent_phase   = 2'd0;
        ent_bit     = 4'd0;
        ent_tx      = tx_q;
        // bit_q reaching last_bit marks the extra finishing cycle before DONE.
        last_bit    = (state_q == S_START || state_q == S_STOP) ? 4'd1 : 4'd9;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    case (instruction_i)
                        2'd0:    ent_state = S_START;
                        2'd1:    ent_state = S_STOP;
                        2'd2:    ent_state = S_READ;
                        default: ent_state = S_WRITE;
                    endcase
                    state_d     = ent_state;
                    busy_d      = 1'b1;
                    div_d       = '0;
                    phase_d     = 2'd0;
                    bit_d       = 4'd0;
                    tx_d        = byte_to_send_i;
                    ent_tx      = byte_to_send_i;
                    // Back-to-back reads NACK the second byte; any other command breaks the chain.
                    nack_d      = (instruction_i == 2'd2) && last_read_q;
                    last_read_d = (instruction_i == 2'd2);
                    enter       = 1'b1;
                end
            end
            S_DONE: begin
                if (!enable_i) begin
                    complete_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                if (bit_q == last_bit) begin
                    busy_d     = 1'b0;
                    complete_d = enable_i;
                    state_d    = enable_i ? S_DONE : S_IDLE;
                    // Byte transfers park SCL low so the next command starts from a low clock.
                    if (state_q == S_WRITE || state_q == S_READ) scl_d = 1'b0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (phase_q == 2'd3) begin
                        phase_d   = 2'd0;
                        bit_d     = bit_q + 4'd1;
                        ent_bit   = bit_q + 4'd1;
                        enter     = (bit_q + 4'd1) != last_bit;
                        if (state_q == S_READ && bit_q == 4'd7) rx_d = shift_q;
                    end else begin
                        phase_d   = phase_q + 2'd1;
                        ent_phase = phase_q + 2'd1;
                        ent_bit   = bit_q;
                        enter     = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase

        if (enter) begin
            case (ent_state)
                S_START: begin
                    case (ent_phase)
                        2'd0:    sda_oe_d = 1'b0;
                        2'd1:    scl_d    = 1'b1;
                        2'd2:    sda_oe_d = 1'b1;
                        default: scl_d    = 1'b0;
                    endcase
                end
                S_STOP: begin
                    case (ent_phase)
                        2'd0: begin
                            scl_d    = 1'b0;
                            sda_oe_d = 1'b1;
                        end
                        2'd1:    scl_d    = 1'b1;
                        2'd2:    sda_oe_d = 1'b0;
                        default: ;
                    endcase
                end
                S_WRITE: begin
                    case (ent_phase)
                        2'd0: begin
                            scl_d    = 1'b0;
                            // MSB first: bit n carries payload bit 7-n, i.e. index ~n[2:0].
                            sda_oe_d = ent_bit[3] ? 1'b0 : ~ent_tx[~ent_bit[2:0]];
                        end
                        2'd2:    scl_d = 1'b1;
                        2'd3:    if (ent_bit[3]) ack_err_d = sda_i;
                        default: ;
                    endcase
                end
                S_READ: begin
                    case (ent_phase)
                        2'd0: begin
                            scl_d    = 1'b0;
                            sda_oe_d = ent_bit[3] ? ~nack_q : 1'b0;
                        end
                        2'd2:    scl_d = 1'b1;
                        2'd3:    if (!ent_bit[3]) shift_d = {shift_q[6:0], sda_i};
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            phase_q     <= 2'd0;
            bit_q       <= 4'd0;
            tx_q        <= 8'h00;
            shift_q     <= 8'h00;
            rx_q        <= 8'h00;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
            ack_err_q   <= 1'b0;
            nack_q      <= 1'b0;
            last_read_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            complete_q  <= complete_d;
            ack_err_q   <= ack_err_d;
            nack_q      <= nack_d;
            last_read_q <= last_read_d;
        end
    end

    assign byte_received_o = rx_q;
    assign complete_o      = complete_q;
    assign ack_error_o     = ack_err_q;
    assign busy_o          = busy_q;
    assign scl_o           = scl_q;
    assign sda_oe_o        = sda_oe_q;
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - scoreboard bench for i2c_byte_master with a simple I2C slave model
module tb_i2c_byte_master;
    localparam int Q = 2;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    i2c_byte_master_if bus ();

    i2c_byte_master #(.QUARTER_DIV(Q)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .enable_i        (bus.enable),
        .instruction_i   (bus.instruction),
        .byte_to_send_i  (bus.byte_to_send),
        .byte_received_o (bus.byte_received),
        .complete_o      (bus.complete),
        .ack_error_o     (bus.ack_error),
        .busy_o          (bus.busy),
        .scl_o           (bus.scl),
        .sda_oe_o        (bus.sda_oe),
        .sda_i           (bus.sda)
    );

    typedef struct {
        int         lat;
        logic       chk_bits;
        logic [8:0] bits;
        logic       ack;
        logic [7:0] rx;
        logic       scl;
        logic       oe;
        int         nst;
        int         nsp;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   errs = 0;
    int   cyc  = 0;

    // Slave model: smode 2 = supply rd_byte during a read, 3 = answer ack_bit after a write.
    logic [1:0] smode   = 2'd0;
    logic [7:0] rd_byte = 8'h00;
    logic       ack_bit = 1'b0;
    int         idx     = 0;
    logic       slave_out;

    assign slave_out = (smode == 2'd2 && idx < 8) ? rd_byte[7 - idx] :
                       (smode == 2'd3 && idx == 8) ? ack_bit : 1'b1;
    assign bus.sda   = bus.sda_oe ? 1'b0 : slave_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(int lat, logic cb, logic [8:0] bits, logic ack, logic [7:0] rx,
                                logic scl, logic oe, int nst, int nsp);
        exp_t e;
        e.lat = lat; e.chk_bits = cb; e.bits = bits; e.ack = ack; e.rx = rx;
        e.scl = scl; e.oe = oe; e.nst = nst; e.nsp = nsp;
        return e;
    endfunction

    // Monitor: tracks bus activity per command and checks against the scoreboard on complete rise.
    int         acc = 0, rises = 0, nst = 0, nsp = 0;
    logic [8:0] bits = '0;
    logic       scl_p = 1'b1, oe_p = 1'b0, busy_p = 1'b0, comp_p = 1'b0;
    always @(negedge clk) begin
        if (bus.busy && !busy_p) begin
            acc = cyc; rises = 0; idx = 0; nst = 0; nsp = 0; bits = '0;
        end else begin
            if (bus.scl && !scl_p) begin
                rises++;
                bits = {bits[7:0], bus.sda};
            end
            if (!bus.scl && scl_p) idx = rises;
            if (bus.scl && scl_p && bus.sda_oe && !oe_p) nst++;
            if (bus.scl && scl_p && !bus.sda_oe && oe_p) nsp++;
        end
        if (bus.complete && !comp_p) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_complete", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency", 32'(cyc - acc), 32'(e.lat));
                chk("ack_error", {31'd0, bus.ack_error}, {31'd0, e.ack});
                chk("byte_received", {24'd0, bus.byte_received}, {24'd0, e.rx});
                chk("scl_end", {31'd0, bus.scl}, {31'd0, e.scl});
                chk("sda_oe_end", {31'd0, bus.sda_oe}, {31'd0, e.oe});
                chk("start_cond", 32'(nst), 32'(e.nst));
                chk("stop_cond", 32'(nsp), 32'(e.nsp));
                if (e.chk_bits) chk("sda_bits", {23'd0, bits}, {23'd0, e.bits});
            end
        end
        scl_p = bus.scl; oe_p = bus.sda_oe; busy_p = bus.busy; comp_p = bus.complete;
    end

    task automatic run_cmd(input logic [1:0] ins, input logic [7:0] b, input int hold);
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1; bus.instruction = ins; bus.byte_to_send = b;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (bus.complete) done = 1'b1;
        end
        if (!done) chk("complete_timeout", 32'd0, 32'd1);
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            chk("hold_busy", {31'd0, bus.busy}, 32'd0);
            chk("hold_complete", {31'd0, bus.complete}, 32'd1);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        chk("complete_clear", {31'd0, bus.complete}, 32'd0);
    endtask

    task automatic wait_busy();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
        end
        if (!seen) chk("busy_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.enable = 1'b0; bus.instruction = 2'd0; bus.byte_to_send = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_scl", {31'd0, bus.scl}, 32'd1);
        chk("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_complete", {31'd0, bus.complete}, 32'd0);
        chk("rst_ack", {31'd0, bus.ack_error}, 32'd0);
        chk("rst_rx", {24'd0, bus.byte_received}, 32'd0);
        rst_ni = 1'b1;

        smode = 2'd0; exp_q.push_back(mk(9, 0, 9'h000, 0, 8'h00, 0, 1, 1, 0)); run_cmd(2'd0, 8'h00, 0);
        smode = 2'd3; ack_bit = 1'b0;
        exp_q.push_back(mk(73, 1, 9'h120, 0, 8'h00, 0, 0, 0, 0)); run_cmd(2'd3, 8'h90, 0);
        ack_bit = 1'b1;
        exp_q.push_back(mk(73, 1, 9'h121, 1, 8'h00, 0, 0, 0, 0)); run_cmd(2'd3, 8'h90, 0);
        smode = 2'd0; exp_q.push_back(mk(9, 0, 9'h000, 1, 8'h00, 0, 1, 1, 0)); run_cmd(2'd0, 8'h00, 0);
        smode = 2'd3; ack_bit = 1'b0;
        exp_q.push_back(mk(73, 1, 9'h122, 0, 8'h00, 0, 0, 0, 0)); run_cmd(2'd3, 8'h91, 0);
        smode = 2'd2; rd_byte = 8'h12;
        exp_q.push_back(mk(73, 1, 9'h024, 0, 8'h12, 0, 1, 0, 0)); run_cmd(2'd2, 8'h00, 0);
        rd_byte = 8'h34;
        exp_q.push_back(mk(73, 1, 9'h069, 0, 8'h34, 0, 0, 0, 0)); run_cmd(2'd2, 8'h00, 0);
        smode = 2'd0; exp_q.push_back(mk(9, 0, 9'h000, 0, 8'h34, 1, 0, 0, 1)); run_cmd(2'd1, 8'h00, 20);

        // Reset in the middle of WRITE bit 4.
        smode = 2'd3; ack_bit = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1; bus.instruction = 2'd3; bus.byte_to_send = 8'h55;
        wait_busy();
        repeat (34) @(negedge clk);
        rst_ni = 1'b0; bus.enable = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        chk("abort_scl", {31'd0, bus.scl}, 32'd1);
        chk("abort_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("abort_complete", {31'd0, bus.complete}, 32'd0);
        end
        smode = 2'd0; exp_q.push_back(mk(9, 0, 9'h000, 0, 8'h00, 0, 1, 1, 0)); run_cmd(2'd0, 8'h00, 0);

        // STOP with enable dropped mid-command: finishes silently.
        @(negedge clk);
        bus.enable = 1'b1; bus.instruction = 2'd1;
        wait_busy();
        repeat (2) @(negedge clk);
        bus.enable = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("drop_complete", {31'd0, bus.complete}, 32'd0);
        end
        chk("drop_busy", {31'd0, bus.busy}, 32'd0);
        chk("drop_scl", {31'd0, bus.scl}, 32'd1);
        chk("drop_sda_oe", {31'd0, bus.sda_oe}, 32'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
